// File: rtl/simon_pkg.sv
// simon_pkg: shared state codes, LFSR constants and colour names for the Simon engine
package simon_pkg;
  typedef enum logic [3:0] {
    E_IDLE     = 4'd0,
    E_APPEND   = 4'd1,
    E_SHOW_ON  = 4'd2,
    E_SHOW_OFF = 4'd3,
    E_INPUT    = 4'd4,
    E_WIN      = 4'd5,
    E_LOSE     = 4'd6
  } state_e;
  localparam logic [3:0] ST_IDLE     = E_IDLE;
  localparam logic [3:0] ST_APPEND   = E_APPEND;
  localparam logic [3:0] ST_SHOW_ON  = E_SHOW_ON;
  localparam logic [3:0] ST_SHOW_OFF = E_SHOW_OFF;
  localparam logic [3:0] ST_INPUT    = E_INPUT;
  localparam logic [3:0] ST_WIN      = E_WIN;
  localparam logic [3:0] ST_LOSE     = E_LOSE;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [1:0] B = 2'd0;
  localparam logic [1:0] G = 2'd1;
  localparam logic [1:0] R = 2'd2;
  localparam logic [1:0] Y = 2'd3;
endpackage

// File: rtl/simon_lfsr.sv
// simon_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) with seed load and zero-seed substitution
module simon_lfsr
  import simon_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         adv,
  input  logic [15:0]  seed,
  output logic [W-1:0] color
);
  logic [15:0] q;
  // load wins over advance; an all-zero seed would lock the register, so it maps to the default
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= LFSR_SEED;
    else if (load) q <= seed == '0 ? LFSR_SEED : seed;
    else if (adv) q <= {q[14:0], ^(q & LFSR_TAPS)};
  assign color = q[W-1:0];
endmodule

// File: rtl/simon_seq_engine.sv
// simon_seq_engine: Simon game core (LFSR sequence, timed playback, handshaked input); define SIMON_TIMEOUT_EN for the player input timeout
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int COLOR_W       = 2,
  parameter int MAX_LEN       = 16,
  parameter int SHOW_TICKS    = 4,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 64,
  parameter int LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        seed,
  input  logic               in_valid,
  input  logic [COLOR_W-1:0] in_color,
  output logic               in_ready,
  output logic               show_valid,
  output logic [COLOR_W-1:0] show_color,
  output logic [LEN_W-1:0]   level,
  output logic [LEN_W-1:0]   step,
  output logic [3:0]         state,
  output logic               win,
  output logic               lose,
  output logic               timeout
);
  localparam int AW   = $clog2(MAX_LEN);
  localparam int HOLD = SHOW_TICKS > GAP_TICKS ? SHOW_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(HOLD + 1);
  logic [TW-1:0]      tick;
  logic [COLOR_W-1:0] mem [MAX_LEN];
  logic [COLOR_W-1:0] lfsr_color, cur;
  logic               go, xfer, last, to_hit;

  if (MAX_LEN < 2 || MAX_LEN > 64 || SHOW_TICKS < 1 || GAP_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_param_check
    $error("simon_seq_engine: parameter out of range");
  end

  assign go         = start && (state == ST_IDLE || state == ST_WIN || state == ST_LOSE);
  assign xfer       = in_valid && state == ST_INPUT;
  assign cur        = mem[step[AW-1:0]];
  assign last       = step == level - LEN_W'(1);
  assign in_ready   = state == ST_INPUT;
  assign show_valid = state == ST_SHOW_ON;
  assign show_color = show_valid ? cur : '0;
  assign win        = state == ST_WIN;
  assign lose       = state == ST_LOSE;

  simon_lfsr #(.W(COLOR_W)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (go),
    .adv   (state == ST_APPEND),
    .seed  (seed),
    .color (lfsr_color)
  );

  // sequence memory is only written while appending; contents before that are never read
  always_ff @(posedge clk)
    if (state == ST_APPEND) mem[level[AW-1:0]] <= lfsr_color;

  // game FSM with shared playback tick counter; level/step advance here
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      level <= '0;
      step  <= '0;
      tick  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_WIN, ST_LOSE:
          if (go) begin
            state <= ST_APPEND;
            level <= '0;
            step  <= '0;
          end
        ST_APPEND: begin
          level <= level + LEN_W'(1);
          step  <= '0;
          tick  <= '0;
          state <= ST_SHOW_ON;
        end
        ST_SHOW_ON:
          if (tick == TW'(SHOW_TICKS - 1)) begin
            tick  <= '0;
            state <= ST_SHOW_OFF;
          end else tick <= tick + TW'(1);
        ST_SHOW_OFF:
          if (tick == TW'(GAP_TICKS - 1)) begin
            tick  <= '0;
            step  <= last ? '0 : step + LEN_W'(1);
            state <= last ? ST_INPUT : ST_SHOW_ON;
          end else tick <= tick + TW'(1);
        ST_INPUT:
          if (xfer) begin
            if (in_color != cur) state <= ST_LOSE;
            else if (last) state <= level == LEN_W'(MAX_LEN) ? ST_WIN : ST_APPEND;
            else step <= step + LEN_W'(1);
          end else if (to_hit) state <= ST_LOSE;
        default: state <= ST_IDLE;
      endcase
    end

`ifdef SIMON_TIMEOUT_EN
  localparam int OW = $clog2(TIMEOUT_TICKS + 1);
  logic [OW-1:0] idle_cnt;
  logic          to_q;
  assign to_hit  = state == ST_INPUT && !xfer && idle_cnt == OW'(TIMEOUT_TICKS - 1);
  assign timeout = to_q;
  // idle counter is zero outside INPUT, so every entry starts a fresh window; flag holds until a new game
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idle_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      idle_cnt <= state == ST_INPUT && !xfer && !to_hit ? idle_cnt + OW'(1) : '0;
      to_q     <= go ? 1'b0 : to_hit ? 1'b1 : to_q;
    end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_simon_seq_engine.sv
// tb_simon_seq_engine: scoreboard bench with a behavioural Simon model and randomized games
module tb_simon_seq_engine;
  localparam int CW = 2, ML = 4, ST = 4, GT = 2, TT = 8, LW = $clog2(ML + 1);
  logic clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [15:0] seed = 0;
  logic [CW-1:0] in_color = 0;
  logic in_ready, show_valid, win, lose, timeout;
  logic [CW-1:0] show_color;
  logic [LW-1:0] level, step;
  logic [3:0] state;
  int total = 0, bad = 0;
  int exp_show[$];
  int exp_end[$];
  int seq[ML];

  simon_seq_engine #(.COLOR_W(CW), .MAX_LEN(ML), .SHOW_TICKS(ST), .GAP_TICKS(GT), .TIMEOUT_TICKS(TT)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .in_valid(in_valid), .in_color(in_color),
    .in_ready(in_ready), .show_valid(show_valid), .show_color(show_color), .level(level), .step(step),
    .state(state), .win(win), .lose(lose), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void gen_seq(input logic [15:0] sd);
    logic [15:0] r;
    r = sd == 16'h0 ? 16'hACE1 : sd;
    for (int i = 0; i < ML; i++) begin
      seq[i] = int'(r) % (1 << CW);
      r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    end
  endfunction

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    ok = in_ready;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ready_wait: in_ready still %0d after %0d cycles", in_ready, n);
    end
  endtask

  task automatic play_game(input logic [15:0] sd, input int fail_lv, input int fail_st, input int abort_lv);
    bit ok, wrong;
    int n, c;
    gen_seq(sd);
    exp_show.push_back(seq[0]);
    seed = sd;
    start = 1;
    tick();
    start = 0;
    seed = 16'($urandom);
    chk("start_state", state, 1);
    chk("start_level", level, 0);
    for (int L = 1; L <= ML; L++) begin
      if (L > 1) for (int i = 0; i < L; i++) exp_show.push_back(seq[i]);
      if (L == abort_lv) begin
        n = 0;
        while (!show_valid && n < 10) begin
          tick();
          n++;
        end
        chk("abort_in_show", show_valid, 1);
        chk("abort_level", level, L);
        reset = 1;
        #1;
        chk("rst_state", state, 0);
        chk("rst_level", level, 0);
        chk("rst_step", step, 0);
        chk("rst_show_valid", show_valid, 0);
        chk("rst_show_color", show_color, 0);
        chk("rst_in_ready", in_ready, 0);
        exp_show.delete();
        tick();
        tick();
        reset = 0;
        tick();
        chk("rst_release_state", state, 0);
        return;
      end
      if (L == 1) begin
        in_valid = 1;
        in_color = CW'(seq[0] + 1);
        n = 0;
        tick();
        while (show_valid && n < 20) begin
          n++;
          tick();
        end
        chk("l1_on_ticks", n, ST);
        in_valid = 0;
        n = 0;
        while (!in_ready && n < 20) begin
          n++;
          tick();
        end
        chk("l1_gap_ticks", n, GT);
      end
      wait_ready(ok);
      if (!ok) return;
      chk("input_level", level, L);
      chk("input_step", step, 0);
      if (L == 2) begin
        start = 1;
        tick();
        start = 0;
        chk("start_ignored_state", state, 4);
        chk("start_ignored_level", level, L);
        chk("start_ignored_step", step, 0);
      end
      for (int i = 0; i < L; i++) begin
        wrong = L == fail_lv && i == fail_st;
        c = wrong ? (seq[i] + 1) % (1 << CW) : seq[i];
        if (wrong) exp_end.push_back(6);
        else if (i == L - 1 && L == ML) exp_end.push_back(5);
        in_valid = 1;
        in_color = CW'(c);
        start = L == 2 && i == 0;
        tick();
        start = 0;
        in_valid = 0;
        if (wrong) begin
          chk("lose_state", state, 6);
          chk("lose_flag", lose, 1);
          in_valid = 1;
          in_color = CW'(seq[i]);
          repeat (3) tick();
          in_valid = 0;
          chk("lose_held", state, 6);
          chk("lose_level", level, L);
          chk("lose_ready", in_ready, 0);
          return;
        end else if (i < L - 1) chk("step_inc", step, i + 1);
        else if (L < ML) begin
          chk("append_after_last", state, 1);
          tick();
          chk("next_show_latency", show_valid, 1);
        end else begin
          chk("win_state", state, 5);
          chk("win_flag", win, 1);
          chk("win_level", level, ML);
          in_valid = 1;
          in_color = CW'(seq[0]);
          repeat (3) tick();
          in_valid = 0;
          chk("win_held", state, 5);
          chk("win_ready", in_ready, 0);
        end
      end
    end
  endtask

  initial begin : monitor
    logic pv, pw, pl;
    int e;
    pv = 0;
    pw = 0;
    pl = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0;
        pw = 0;
        pl = 0;
        continue;
      end
      if (show_valid && !pv) begin
        if (exp_show.size() == 0) chk("unexpected_show", 1, 0);
        else begin
          e = exp_show.pop_front();
          chk("show_color", show_color, e);
        end
      end
      if ((win && !pw) || (lose && !pl)) begin
        if (exp_end.size() == 0) chk("unexpected_end", state, 0);
        else begin
          e = exp_end.pop_front();
          chk("end_state", state, e);
        end
      end
      pv = show_valid;
      pw = win;
      pl = lose;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish, state=%0d", state);
    $fatal(1);
  end

  initial begin : stim
    bit ok;
    int fl, fs;
    reset = 1;
    #1;
    tick();
    chk("reset_state", state, 0);
    chk("reset_level", level, 0);
    chk("reset_step", step, 0);
    chk("reset_show_valid", show_valid, 0);
    chk("reset_show_color", show_color, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_win", win, 0);
    chk("reset_lose", lose, 0);
    chk("reset_timeout", timeout, 0);
    reset = 0;
    tick();
    play_game(16'h0001, 0, 0, 0);
    play_game(16'h0000, 3, 1, 0);
    play_game(16'($urandom), 0, 0, 3);
    play_game(16'($urandom), 0, 0, 0);
    for (int g = 0; g < 8; g++) begin
      fl = $urandom_range(ML, 0);
      fs = fl > 0 ? $urandom_range(fl - 1, 0) : 0;
      play_game(16'($urandom), fl, fs, 0);
    end
    gen_seq(16'h1234);
    exp_show.push_back(seq[0]);
    seed = 16'h1234;
    start = 1;
    tick();
    start = 0;
    wait_ready(ok);
`ifdef SIMON_TIMEOUT_EN
    exp_end.push_back(6);
    repeat (TT - 1) tick();
    chk("timeout_not_yet", state, 4);
    tick();
    chk("timeout_state", state, 6);
    chk("timeout_flag", timeout, 1);
    gen_seq(16'h4321);
    exp_show.push_back(seq[0]);
    seed = 16'h4321;
    start = 1;
    tick();
    start = 0;
    chk("timeout_cleared", timeout, 0);
`else
    repeat (1000) tick();
    chk("no_timeout_state", state, 4);
    chk("no_timeout_flag", timeout, 0);
`endif
    reset = 1;
    tick();
    exp_show.delete();
    reset = 0;
    tick();
    chk("final_state", state, 0);
    chk("show_queue_empty", exp_show.size(), 0);
    chk("end_queue_empty", exp_end.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/simon_seq_engine.md
Name: simon_seq_engine

Overview:
Parametrised Simon game core that generalises the fixed 4-colour, switch-loaded pattern game.
- Generates a pseudo-random colour sequence of up to MAX_LEN steps from an internal LFSR.
- Plays the sequence back with programmable on/off timing, then accepts player colours through a valid/ready handshake.
- Appends one step per cleared level and reports win or lose.
- Sits between the board I/O (keys, switches, LEDs) and the HEX display decoders.

Parameters:
- COLOR_W, 2, bits per colour; 2^COLOR_W colours.
- MAX_LEN, 16, sequence depth and winning level, range 2..64.
- SHOW_TICKS, 4, clocks each colour is shown, ≥1.
- GAP_TICKS, 2, blank clocks after each shown colour, ≥1.
- TIMEOUT_TICKS, 64, player input timeout, used only with the optional feature.
- LEN_W, $clog2(MAX_LEN+1), derived width of level and index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a new game, pulse.
- seed  in  16  LFSR seed, sampled on an accepted start.
- in_valid  in  1  player colour present.
- in_color  in  COLOR_W  player colour.
- in_ready  out  1  engine accepting input.
- show_valid  out  1  colour being displayed.
- show_color  out  COLOR_W  displayed colour.
- level  out  LEN_W  current sequence length.
- step  out  LEN_W  current index within the sequence.
- state  out  4  FSM state code, for HEX display.
- win  out  1  held high in WIN.
- lose  out  1  held high in LOSE.
- timeout  out  1  lose caused by timeout.

Behaviour:
- Reset (asynchronous, any cycle, including mid-game):
  - state=IDLE; level=0; step=0; LFSR=16'hACE1.
  - All outputs 0; sequence memory contents don't-care.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts left, feedback into bit 0.
  - Advances only in APPEND.
  - start loads seed; seed==0 substitutes 16'hACE1.
- State codes: IDLE=0, APPEND=1, SHOW_ON=2, SHOW_OFF=3, INPUT=4, WIN=5, LOSE=6.
- IDLE: start=1 → load LFSR, level<=0, go APPEND next cycle.
- APPEND (1 cycle):
  - mem[level] <= lfsr[COLOR_W-1:0]; level <= level+1; LFSR steps; step <= 0.
  - → SHOW_ON.
- SHOW_ON:
  - show_valid=1, show_color=mem[step], for exactly SHOW_TICKS cycles.
  - → SHOW_OFF.
- SHOW_OFF:
  - show_valid=0, show_color=0, for exactly GAP_TICKS cycles.
  - On exit: if step==level-1 → step<=0, INPUT; else step<=step+1, SHOW_ON.
- INPUT:
  - in_ready=1; a transfer occurs when in_valid && in_ready.
  - Match with step==level-1 → WIN if level==MAX_LEN, else APPEND.
  - Match otherwise → step<=step+1, stay in INPUT.
  - Mismatch → LOSE.
  - One transfer per cycle; held in_valid counts as a new transfer each cycle.
- WIN / LOSE:
  - Sticky; win or lose high, in_ready=0.
  - start → restart exactly as from IDLE.
- Ignored inputs:
  - start in APPEND, SHOW_ON, SHOW_OFF or INPUT.
  - in_valid outside INPUT.
  - If start and in_valid arrive together in INPUT, start is ignored and the input is processed.
- Latency:
  - start to first show_valid: 2 cycles (IDLE→APPEND→SHOW_ON).
  - Last correct input to next level's first show_valid: 2 cycles.
- Width rule: level never exceeds MAX_LEN; step is always < level.

Optional Feature:
SIMON_TIMEOUT_EN
- Defined:
  - A counter runs in INPUT and clears on entry and on each transfer.
  - Reaching TIMEOUT_TICKS idle cycles → LOSE with timeout=1.
  - timeout clears on start or reset.
- Undefined: INPUT waits indefinitely; timeout tied to 0; no counter logic.

Decomposition:
- Package simon_pkg holds:
  - state enum and 4-bit codes;
  - LFSR tap mask 16'hB400;
  - default seed 16'hACE1;
  - colour localparams B=0, G=1, R=2, Y=3 for COLOR_W=2.
- Sub-module simon_lfsr: 16-bit LFSR with load, step and seed-zero substitution.
- Sequence memory, tick counters and FSM stay in the top.

Test Plan:
- Reset mid-SHOW_ON (level=3) → next cycle all outputs 0, state=0; after release, start restarts with level=1.
- seed=16'h0001, MAX_LEN=2 → both colours echoed correctly → win=1, level=2, state=5 held until start.
- Level 1 shown → show_valid high exactly 4 cycles, then low 2 cycles, then in_ready=1.
- At level 3, wrong colour on step 1 → lose=1, state=6 next cycle; further in_valid has no effect.
- in_valid pulsed during SHOW_ON and start pulsed during INPUT → no state, step or level change.
- SIMON_TIMEOUT_EN defined with TIMEOUT_TICKS=8, no input → LOSE, timeout=1 after 8 cycles; undefined → still INPUT after 1000 cycles.
